// File: rtl/spi_master.sv
// SPI master, mode 0/1 selectable by CPHA, LSB-first byte transfers with sclk half-period DIV.
// Define SPI_MASTER_BURST_EN to chain back-to-back bytes inside one ss_n frame.
module spi_master #(
    parameter int CPHA = 0,
    parameter int DIV  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       ss_n,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [3:0] edge_cnt_q, edge_cnt_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       ss_n_q, ss_n_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       tx_ready_q, tx_ready_d;

    logic       accept_s;
    logic       tick_s;
    logic       last_edge_s;
    logic       rising_s;
    logic       sample_s;
    logic       drive_s;

    // In CPHA=0 bit0 leaves on mosi immediately, so the shifter holds the remaining bits.
    function automatic logic [7:0] load_shift(input logic [7:0] d);
        return (CPHA == 0) ? {1'b0, d[7:1]} : d;
    endfunction

    function automatic logic load_mosi(input logic [7:0] d);
        return (CPHA == 0) ? d[0] : 1'b0;
    endfunction

    assign accept_s    = tx_valid & tx_ready_q;
    assign tick_s      = (div_cnt_q == 8'd0);
    assign last_edge_s = (edge_cnt_q == 4'd15);
    assign rising_s    = ~edge_cnt_q[0];
    assign sample_s    = (CPHA == 0) ? rising_s : ~rising_s;
    assign drive_s     = (CPHA == 0) ? (~rising_s & ~last_edge_s) : rising_s;

    // Next-state and datapath logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        ss_n_d     = ss_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                ss_n_d     = 1'b1;
                sclk_d     = 1'b0;
                mosi_d     = 1'b0;
                busy_d     = 1'b0;
                div_cnt_d  = 8'd0;
                edge_cnt_d = 4'd0;
                if (accept_s) begin
                    state_d   = S_SETUP;
                    ss_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    div_cnt_d = DIV_RELOAD;
                    tx_sh_d   = load_shift(tx_data);
                    mosi_d    = load_mosi(tx_data);
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SETUP, S_XFER: begin
                if (tick_s) begin
                    sclk_d     = ~sclk_q;
                    div_cnt_d  = DIV_RELOAD;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    state_d    = S_XFER;
                    if (sample_s) begin
                        rx_sh_d = {miso, rx_sh_q[7:1]};
                    end else begin
                        rx_sh_d = rx_sh_q;
                    end
                    if (drive_s) begin
                        mosi_d  = tx_sh_q[0];
                        tx_sh_d = {1'b0, tx_sh_q[7:1]};
                    end else begin
                        mosi_d  = mosi_q;
                    end
                    if (last_edge_s) begin
                        rx_data_d  = rx_sh_d;
                        rx_valid_d = 1'b1;
`ifdef SPI_MASTER_BURST_EN
                        // Next byte restarts edge numbering on the same cadence.
                        if (accept_s) begin
                            state_d = S_XFER;
                            tx_sh_d = load_shift(tx_data);
                            mosi_d  = (CPHA == 0) ? tx_data[0] : mosi_q;
                        end else begin
                            state_d = S_HOLD;
                        end
`else
                        state_d = S_HOLD;
`endif
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end

            S_HOLD: begin
                if (tick_s) begin
                    state_d   = S_GAP;
                    ss_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    mosi_d    = 1'b0;
                    div_cnt_d = DIV_RELOAD;
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end

            S_GAP: begin
                if (tick_s) begin
                    state_d   = S_IDLE;
                    div_cnt_d = 8'd0;
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d    = S_IDLE;
                ss_n_d     = 1'b1;
                sclk_d     = 1'b0;
                mosi_d     = 1'b0;
                busy_d     = 1'b0;
                div_cnt_d  = 8'd0;
                edge_cnt_d = 4'd0;
            end
        endcase

`ifdef SPI_MASTER_BURST_EN
        // Ready is registered, so open the burst window one cycle ahead of edge 16.
        tx_ready_d = (state_d == S_IDLE) ||
                     ((state_q == S_XFER) && last_edge_s && (div_cnt_q == 8'd1));
`else
        tx_ready_d = (state_d == S_IDLE);
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= 8'd0;
            edge_cnt_q <= 4'd0;
            tx_sh_q    <= 8'd0;
            rx_sh_q    <= 8'd0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            ss_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ss_n_q     <= ss_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign ss_n     = ss_n_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;

endmodule
